// File: rtl/score_bank_pkg.sv
// Shared definitions for the score result collector: FSM states, biased-zero
// helper and FIFO entry width helper.
package score_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Scores are biased unsigned values; the bias is the midpoint of the range.
  function automatic int unsigned zero_bias(input int unsigned score_w);
    return 32'd1 << (score_w - 1);
  endfunction

  // FIFO entry is packed as {score, id, chan}.
  function automatic int unsigned fifo_entry_w(input int unsigned score_w,
                                               input int unsigned id_w,
                                               input int unsigned ch_w);
    return score_w + id_w + ch_w;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO. Head entry is visible on o_rd_data
// whenever o_count is non-zero. A push is accepted when full if a pop happens
// in the same cycle.
module result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop     = i_rd_en && (r_count != '0);
  assign w_push    = i_wr_en && (!o_full || w_pop);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since r_count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/score_result_collector.sv
// Collects per-channel (score, id) results into holding registers, serialises
// them round-robin into a FWFT output FIFO and tracks the per-query maximum.
// Optional build macro SCORE_THRESHOLD_FILTER_EN: granted entries scoring
// below thr are used for the maximum but not forwarded to the stream.
//
// state  | meaning
// IDLE   | no query open; arriving results are stray
// ACTIVE | query open, results captured
// DRAIN  | query ended, flushing holding registers
// REPORT | one cycle, max_vld asserted
module score_result_collector
  import score_bank_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned ID_WIDTH    = 48,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CH_WIDTH    = $clog2(CHANNELS),
  parameter int unsigned ZERO        = zero_bias(SCORE_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS*SCORE_WIDTH-1:0] res_score,
  input  logic [CHANNELS*ID_WIDTH-1:0]    res_id,
  input  logic [CHANNELS-1:0]             res_vld,
  input  logic                            query_start,
  input  logic                            query_end,
  input  logic [SCORE_WIDTH-1:0]          thr,
  output logic [SCORE_WIDTH-1:0]          out_score,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic [CH_WIDTH-1:0]             out_chan,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [SCORE_WIDTH-1:0]          max_score,
  output logic [ID_WIDTH-1:0]             max_id,
  output logic                            max_vld,
  output logic [CHANNELS-1:0]             overflow,
  output logic                            stray,
  output logic                            busy
);

  localparam logic [SCORE_WIDTH-1:0] ZERO_V = SCORE_WIDTH'(ZERO);
  localparam int unsigned ENTRY_W = fifo_entry_w(SCORE_WIDTH, ID_WIDTH, CH_WIDTH);

  state_t                  r_state;
  logic [CHANNELS-1:0]     r_hold_vld;
  logic [SCORE_WIDTH-1:0]  r_hold_score [CHANNELS];
  logic [ID_WIDTH-1:0]     r_hold_id    [CHANNELS];
  logic [CH_WIDTH-1:0]     r_ptr;
  logic [SCORE_WIDTH-1:0]  r_max_score;
  logic [ID_WIDTH-1:0]     r_max_id;
  logic                    r_max_vld;
  logic [CHANNELS-1:0]     r_overflow;
  logic                    r_stray;
  logic                    r_busy;

  logic                    w_cand_vld;
  logic [CH_WIDTH-1:0]     w_cand_ch;
  logic [SCORE_WIDTH-1:0]  w_cand_score;
  logic [ID_WIDTH-1:0]     w_cand_id;
  logic                    w_filtered;
  logic                    w_room;
  logic                    w_gnt_vld;
  logic [CHANNELS-1:0]     w_gnt_1h;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_capture_ok;
  logic                    w_drained;
  logic [ENTRY_W-1:0]      w_wr_data;
  logic [ENTRY_W-1:0]      w_rd_data;

  function automatic logic [CH_WIDTH-1:0] rr_idx(input logic [CH_WIDTH-1:0] base,
                                                 input int off);
    return CH_WIDTH'((int'(base) + off) % int'(CHANNELS));
  endfunction

  // Round-robin search: the occupied hold closest to r_ptr wins.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_ch  = r_ptr;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (r_hold_vld[rr_idx(r_ptr, i)]) begin
        w_cand_vld = 1'b1;
        w_cand_ch  = rr_idx(r_ptr, i);
      end
    end
  end

  assign w_cand_score = r_hold_score[w_cand_ch];
  assign w_cand_id    = r_hold_id[w_cand_ch];

`ifdef SCORE_THRESHOLD_FILTER_EN
  assign w_filtered = (w_cand_score < thr);
`else
  logic w_unused_thr;
  assign w_unused_thr = ^thr;
  assign w_filtered   = 1'b0;
`endif

  // A filtered entry never reaches the FIFO, so it needs no space there.
  assign out_vld      = (fifo_count != '0);
  assign w_pop        = out_vld && out_rdy;
  assign w_room       = !w_fifo_full || w_pop;
  assign w_gnt_vld    = w_cand_vld && (w_room || w_filtered);
  assign w_gnt_1h     = w_gnt_vld ? (CHANNELS'(1) << w_cand_ch) : '0;
  assign w_push       = w_gnt_vld && !w_filtered;
  assign w_wr_data    = {w_cand_score, w_cand_id, w_cand_ch};
  assign w_capture_ok = (r_state == ACTIVE) || (r_state == DRAIN);
  // A result arriving this cycle still belongs to the query, so hold off REPORT.
  assign w_drained    = (r_hold_vld == '0) && !w_gnt_vld && (res_vld == '0);

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_data),
    .i_rd_en   (out_rdy),
    .o_rd_data (w_rd_data),
    .o_count   (fifo_count),
    .o_full    (w_fifo_full)
  );

  assign out_score = w_rd_data[ENTRY_W-1 -: SCORE_WIDTH];
  assign out_id    = w_rd_data[CH_WIDTH +: ID_WIDTH];
  assign out_chan  = w_rd_data[CH_WIDTH-1:0];

  // Holding registers: a load beats a same-cycle grant; otherwise an occupied
  // hold drops the new result and flags overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_vld <= '0;
      r_overflow <= '0;
      r_stray    <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        r_hold_score[c] <= '0;
        r_hold_id[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (res_vld[c]) begin
          if (!w_capture_ok) begin
            r_stray <= 1'b1;
          end else if (!r_hold_vld[c] || w_gnt_1h[c]) begin
            r_hold_vld[c]   <= 1'b1;
            r_hold_score[c] <= res_score[c*SCORE_WIDTH +: SCORE_WIDTH];
            r_hold_id[c]    <= res_id[c*ID_WIDTH +: ID_WIDTH];
          end else begin
            r_overflow[c] <= 1'b1;
          end
        end else if (w_gnt_1h[c]) begin
          r_hold_vld[c] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the channel just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ptr <= '0;
    else if (w_gnt_vld) r_ptr <= rr_idx(w_cand_ch, 1);
  end

  // Query FSM with running maximum; opening a query resets the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_max_score <= ZERO_V;
      r_max_id    <= '0;
      r_max_vld   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_gnt_vld && (w_cand_score > r_max_score)) begin
        r_max_score <= w_cand_score;
        r_max_id    <= w_cand_id;
      end
      case (r_state)
        IDLE: begin
          if (query_start) begin
            r_state     <= ACTIVE;
            r_busy      <= 1'b1;
            r_max_score <= ZERO_V;
            r_max_id    <= '0;
          end
        end
        ACTIVE: begin
          if (query_end) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drained) begin
            r_state   <= REPORT;
            r_busy    <= 1'b0;
            r_max_vld <= 1'b1;
          end
        end
        REPORT: begin
          r_state   <= IDLE;
          r_max_vld <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign max_score = r_max_score;
  assign max_id    = r_max_id;
  assign max_vld   = r_max_vld;
  assign overflow  = r_overflow;
  assign stray     = r_stray;
  assign busy      = r_busy;

endmodule

// File: tb/tb_score_result_collector.sv
// Directed bench for score_result_collector (CHANNELS=4, SCORE_WIDTH=12).
module tb_score_result_collector;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [47:0]   res_score = '0;
  logic [191:0]  res_id = '0;
  logic [3:0]    res_vld = '0;
  logic          query_start = 1'b0;
  logic          query_end = 1'b0;
  logic [11:0]   thr = 12'd2200;
  logic [11:0]   out_score;
  logic [47:0]   out_id;
  logic [1:0]    out_chan;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [4:0]    fifo_count;
  logic [11:0]   max_score;
  logic [47:0]   max_id;
  logic          max_vld;
  logic [3:0]    overflow;
  logic          stray;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  score_result_collector dut (
    .clk         (clk),
    .rst         (rst),
    .res_score   (res_score),
    .res_id      (res_id),
    .res_vld     (res_vld),
    .query_start (query_start),
    .query_end   (query_end),
    .thr         (thr),
    .out_score   (out_score),
    .out_id      (out_id),
    .out_chan    (out_chan),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .fifo_count  (fifo_count),
    .max_score   (max_score),
    .max_id      (max_id),
    .max_vld     (max_vld),
    .overflow    (overflow),
    .stray       (stray),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input int ch, input int sc, input logic [47:0] id);
    logic [11:0] s;
    s = 12'(sc);
    res_score[ch*12 +: 12] = s;
    res_id[ch*48 +: 48]    = id;
    res_vld[ch]            = 1'b1;
  endtask

  task automatic wait_report(input string tag);
    int n = 0;
    while (max_vld !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, max_vld, 1);
  endtask

  initial begin
    int order [4];
    order = '{2, 3, 0, 1};

    // Reset state
    step(); step();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_max_score", max_score, 2048);
    chk("rst_max_id", max_id, 0);
    chk("rst_max_vld", max_vld, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stray", stray, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Basic flow: one result on ch1
    query_start = 1'b1; step(); query_start = 1'b0;
    chk("basic_busy", busy, 1);
    drive(1, 2100, 48'd7); step(); res_vld = '0;
    chk("basic_latency_no_vld", out_vld, 0);
    step();
    chk("basic_out_vld", out_vld, 1);
    chk("basic_out_score", out_score, 2100);
    chk("basic_out_id", out_id, 7);
    chk("basic_out_chan", out_chan, 1);
    query_end = 1'b1; step(); query_end = 1'b0;
    chk("basic_drain_busy", busy, 1);
    chk("basic_fifo_popped", fifo_count, 0);
    step();
    chk("basic_max_vld", max_vld, 1);
    chk("basic_max_score", max_score, 2100);
    chk("basic_max_id", max_id, 7);
    chk("basic_report_busy", busy, 0);
    step();
    chk("basic_max_vld_pulse", max_vld, 0);

    // Round robin starting at pointer 2
    query_start = 1'b1; step(); query_start = 1'b0;
    for (int c = 0; c < 4; c++) drive(c, 2200 + c, 48'(10 + c));
    step(); res_vld = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_chan", out_chan, order[k]);
      chk("rr_score", out_score, 2200 + order[k]);
    end
    query_end = 1'b1; step(); query_end = 1'b0;
    wait_report("rr_report");
    chk("rr_max_score", max_score, 2203);
    chk("rr_max_id", max_id, 13);
    step();

    // Overflow with full FIFO and backpressure
    query_start = 1'b1; step(); query_start = 1'b0;
    out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      res_vld = '0;
      drive(i % 4, 2048 + i, 48'(100 + i));
      step();
    end
    res_vld = '0;
    step();
    chk("ovf_fifo_full", fifo_count, 16);
    drive(0, 3000, 48'd200); step();
    drive(0, 3001, 48'd201); step(); res_vld = '0;
    chk("ovf_flag", overflow, 4'b0001);
    chk("ovf_count_stays", fifo_count, 16);
    chk("ovf_head_score", out_score, 2048);
    step();
    chk("ovf_hold_stable_score", out_score, 2048);
    chk("ovf_hold_stable_id", out_id, 100);
    out_rdy = 1'b1; step();
    chk("ovf_push_pop_full_count", fifo_count, 16);
    chk("ovf_next_score", out_score, 2049);
    query_end = 1'b1; step(); query_end = 1'b0;
    wait_report("ovf_report");
    chk("ovf_max_score", max_score, 3000);
    chk("ovf_max_id", max_id, 200);
    for (int i = 0; i < 20; i++) step();
    chk("ovf_drained", fifo_count, 0);
    chk("ovf_sticky", overflow, 4'b0001);

    // Tie keeps earlier winner; lower score ignored
    query_start = 1'b1; step(); query_start = 1'b0;
    chk("tie_max_cleared", max_score, 2048);
    chk("tie_ovf_not_cleared", overflow, 4'b0001);
    drive(0, 2500, 48'd1); step(); res_vld = '0; step();
    drive(1, 2500, 48'd2); step(); res_vld = '0; step();
    drive(2, 2499, 48'd3); step(); res_vld = '0; step(); step();
    query_end = 1'b1; step(); query_end = 1'b0;
    wait_report("tie_report");
    chk("tie_max_score", max_score, 2500);
    chk("tie_max_id", max_id, 1);
    step();

    // Threshold behaviour (thr=2200)
    query_start = 1'b1; step(); query_start = 1'b0;
    drive(0, 2100, 48'd20); step(); res_vld = '0;
    drive(1, 2300, 48'd21); step(); res_vld = '0;
`ifdef SCORE_THRESHOLD_FILTER_EN
    chk("thr_low_filtered", out_vld, 0);
    step();
    chk("thr_high_vld", out_vld, 1);
    chk("thr_high_score", out_score, 2300);
`else
    chk("thr_low_forwarded", out_vld, 1);
    chk("thr_low_score", out_score, 2100);
    step();
    chk("thr_high_score", out_score, 2300);
`endif
    chk("thr_high_id", out_id, 21);
    step();
    chk("thr_stream_empty", out_vld, 0);
    query_end = 1'b1; step(); query_end = 1'b0;
    wait_report("thr_report");
    chk("thr_max_score", max_score, 2300);
    chk("thr_max_id", max_id, 21);
    step();

    // Stray result in IDLE, then reset in the middle of DRAIN
    drive(3, 2600, 48'd30); step(); res_vld = '0;
    chk("stray_set", stray, 1);
    query_start = 1'b1; step(); query_start = 1'b0;
    query_end = 1'b1; step(); query_end = 1'b0;
    drive(0, 2600, 48'd9);
    chk("mid_drain_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    res_vld = '0;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_max_score", max_score, 2048);
    chk("arst_max_id", max_id, 0);
    chk("arst_max_vld", max_vld, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_stray", stray, 0);
    chk("arst_busy", busy, 0);
    step();
    chk("arst_no_pulse_a", max_vld, 0);
    rst = 1'b0;
    step();
    chk("arst_no_pulse_b", max_vld, 0);
    chk("arst_idle_busy", busy, 0);
    step();
    chk("arst_no_pulse_c", max_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_result_collector.md
Name: score_result_collector

Overview:
- Successor stage to the score bank's raw result outputs. Collects per-channel (score, ID) results from CHANNELS scoring-module outputs and buffers them in per-channel holding registers.
- A round-robin arbiter serialises buffered results into one FIFO-backed valid/ready stream.
- Tracks the per-query maximum score and its ID, and reports it once the query has fully drained.

Parameters:
- SCORE_WIDTH, 12, score width; scores are biased unsigned values.
- ID_WIDTH, 48, target sequence ID width.
- CHANNELS, 4, number of result channels (2 per scoring module); must be ≥2.
- FIFO_DEPTH, 16, output FIFO entries; must be a power of 2.
- CH_WIDTH, $clog2(CHANNELS), channel index width.
- ZERO, 2**(SCORE_WIDTH-1), biased zero; reset value of the max score.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- res_score  in  CHANNELS*SCORE_WIDTH  per-channel score; channel c occupies bits [c*SCORE_WIDTH +: SCORE_WIDTH].
- res_id  in  CHANNELS*ID_WIDTH  per-channel ID; same slicing as res_score.
- res_vld  in  CHANNELS  one-cycle valid per channel.
- query_start  in  1  pulse; opens a new query.
- query_end  in  1  pulse; no more results will arrive for this query.
- thr  in  SCORE_WIDTH  forwarding threshold; used only with the optional feature.
- out_score  out  SCORE_WIDTH  stream score.
- out_id  out  ID_WIDTH  stream ID.
- out_chan  out  CH_WIDTH  source channel of the stream entry.
- out_vld  out  1  stream valid.
- out_rdy  in  1  stream ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- max_score  out  SCORE_WIDTH  query maximum score.
- max_id  out  ID_WIDTH  ID of the query maximum.
- max_vld  out  1  one-cycle pulse when the maximum is final.
- overflow  out  CHANNELS  sticky per-channel drop flags.
- stray  out  1  sticky flag: result arrived outside a query.
- busy  out  1  high in ACTIVE or DRAIN.

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-high, port rst.
- Reset values:
  - All holding registers empty; FIFO empty.
  - out_vld=0, fifo_count=0, max_score=ZERO, max_id=0, max_vld=0, overflow=0, stray=0, busy=0.
  - Round-robin pointer=0; FSM in IDLE.
- FSM states and transitions:
  - IDLE: query_start → ACTIVE. Entering ACTIVE clears max_score to ZERO and max_id to 0; overflow and stray are NOT cleared.
  - ACTIVE: query_end → DRAIN. A query_start while ACTIVE is ignored.
  - DRAIN: go to REPORT when all holding registers are empty and no grant is in flight.
  - REPORT: one cycle with max_vld=1, then IDLE.
  - query_start and query_end in the same cycle in IDLE: start wins; end is ignored.
- Capture:
  - res_vld[c] in ACTIVE or DRAIN loads hold[c] at the next edge.
  - If hold[c] is occupied and not granted that cycle, the new result is dropped and overflow[c] is set.
  - If hold[c] is granted in the same cycle, the load wins and overflow is not set.
  - Results arriving in IDLE or REPORT are dropped and set stray.
- Arbitration:
  - Grant is issued only when the FIFO is not full, counting same-cycle pops.
  - The grant searches occupied holds starting at the pointer. After granting c, pointer = (c+1) mod CHANNELS.
  - At most one grant per cycle.
  - The granted entry is written to the FIFO at the next edge, and the hold is cleared.
- Max update:
  - On grant, if score > max_score (unsigned, strict), update max_score and max_id.
  - Ties keep the earlier winner.
  - The max update is independent of FIFO backpressure: backpressure delays the grant, not correctness.
- Latency: res_vld at cycle N → hold loaded at N+1 → earliest grant at N+1 → out_vld at N+2 (FWFT FIFO, empty FIFO, out_rdy=1).
- Stream handshake:
  - Pop when out_vld && out_rdy.
  - out_* must be held stable while out_vld && !out_rdy.
  - Simultaneous push and pop when full is permitted.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: SCORE_THRESHOLD_FILTER_EN.
- Defined:
  - A granted entry with score < thr is not written to the FIFO, but is still used for the max update.
  - The grant does not require FIFO space when the granted entry will be filtered.
- Undefined: thr is ignored and every granted entry is forwarded.

Decomposition:
- Package score_bank_pkg:
  - ZERO-bias function.
  - FSM state localparams: IDLE=0, ACTIVE=1, DRAIN=2, REPORT=3.
  - FIFO entry width helper (SCORE_WIDTH + ID_WIDTH + CH_WIDTH).
- Sub-module result_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, and outputs count and full.

Test Plan (CHANNELS=4, SCORE_WIDTH=12, ZERO=2048):
- Basic flow: query_start; ch1 score 2100/id 7 at cycle 5; query_end at cycle 8; out_rdy=1 → out_vld at cycle 7 with (2100, 7, chan 1); max_vld pulse with max_score=2100, max_id=7.
- Round-robin fairness: all 4 channels valid in one cycle with pointer=2 → outputs in order ch2, ch3, ch0, ch1 on consecutive cycles.
- Overflow: out_rdy=0 until the FIFO holds 16 entries; then ch0 valid on two consecutive cycles → overflow[0]=1 and fifo_count stays 16.
- Tie and max: scores 2500 (id 1) then 2500 (id 2) → max_id=1; a later 2499 does not change the max.
- Stray and reset: res_vld in IDLE → stray=1; assert rst mid-DRAIN → all outputs return to reset values with no max_vld pulse.
- Filter (macro defined, thr=2200): scores 2100 and 2300 → only 2300 is streamed; max_score=2300.
